ahb_slv_mem: RTL and testbench

AHB_SLV_MEM -- requirements
Module: ahb_slv_mem

---
 rtl/ahb_slv_mem.sv | 135 +++++++++++++
 tb/tb_ahb_slv_mem.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slv_mem.sv
// AHB-Lite slave backed by a word-organised memory with configurable wait states.
// Illegal transfers (out of range, oversized, misaligned) get a two-cycle ERROR response.
module ahb_slv_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hsel,
    input  logic [1:0]            Htrans,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [3:0]            Hprot,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hreadyin,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hreadyout,
    output logic                  Hresp
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  capture;
    logic                  misaligned;
    logic                  xfer_err;
    logic                  data_done;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  unused_ok;

    always_comb begin
        misaligned = 1'b0;
        case (Hsize)
            3'd1:    misaligned = Haddr[0];
            3'd2:    misaligned = |Haddr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign xfer_err = ({1'b0, Haddr} >= MEM_BYTES) | (Hsize > 3'd2) | misaligned;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        Hreadyout = 1'b1;
        Hresp     = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;
        capture   = 1'b0;
        case (state_q)
            DATA:    Hreadyout = (wait_q == 4'd0);
            ERR1:    begin Hreadyout = 1'b0; Hresp = 1'b1; end
            ERR2:    Hresp = 1'b1;
            default: ;
        endcase

        // A new address phase is only taken while the current data phase is completing.
        if (Hreadyout) begin
            if (Hsel && Hreadyin && Htrans[1]) begin
                capture = 1'b1;
                state_d = xfer_err ? ERR1 : DATA;
                wait_d  = xfer_err ? 4'd0 : 4'(WAIT_STATES);
            end else begin
                state_d = IDLE;
                wait_d  = 4'd0;
            end
        end else if (state_q == ERR1) begin
            state_d = ERR2;
        end else begin
            state_d = DATA;
            wait_d  = wait_q - 4'd1;
        end
    end

    // NOTE: sequential state uses <= so every flop updates from pre-edge values.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (capture) begin
                addr_q  <= Haddr;
                write_q <= Hwrite;
                size_q  <= Hsize;
            end
        end
    end

    assign data_done = (state_q == DATA) && (wait_q == 4'd0);
    assign wr_en     = data_done && write_q;
    assign idx       = addr_q[IDX_W+1:2];

    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be = 4'b0001 << addr_q[1:0];
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // NOTE: zeroing every word on reset keeps the array in flops rather than a RAM macro;
    // that is the price of a memory that must read back 0 after reset.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= Hwdata[8*b +: 8];
            end
        end
    end

    assign Hrdata = (data_done && !write_q) ? mem[idx] : '0;

    assign unused_ok = ^{Hprot, Htrans[0], addr_q[ADDR_WIDTH-1:IDX_W+2]};

endmodule

// File: tb/tb_ahb_slv_mem.sv
// Bench for ahb_slv_mem: two instances (0 and 3 wait states) checked every cycle against
// a per-cycle expected-response queue and a byte-addressed memory model.
module tb_ahb_slv_mem;

    typedef struct {
        bit          ready;
        bit          resp;
        bit          rd;
        bit          wr;
        int unsigned addr;
        int unsigned size;
    } beat_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel     [2];
    logic [1:0]  htrans   [2];
    logic [31:0] haddr    [2];
    logic        hwrite   [2];
    logic [2:0]  hsize    [2];
    logic [3:0]  hprot    [2];
    logic [31:0] hwdata   [2];
    logic        hreadyin [2];
    wire  [1:0]       hreadyout;
    wire  [1:0]       hresp;
    wire  [1:0][31:0] hrdata;

    beat_t       pend [2][8];
    int          pend_n [2];
    int          pend_pos [2];
    beat_t       cur [2];
    bit          acc [2];
    logic [7:0]  mb [2][1024];
    bit          started = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata [2];
    int          low_run [2];
    int          last_low [2];

    initial forever #5 clk = ~clk;

    ahb_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .Hclk(clk), .Hreset(hreset), .Hsel(hsel[0]), .Htrans(htrans[0]), .Haddr(haddr[0]),
        .Hwrite(hwrite[0]), .Hsize(hsize[0]), .Hprot(hprot[0]), .Hwdata(hwdata[0]),
        .Hreadyin(hreadyin[0]), .Hrdata(hrdata[0]), .Hreadyout(hreadyout[0]), .Hresp(hresp[0])
    );

    ahb_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .Hclk(clk), .Hreset(hreset), .Hsel(hsel[1]), .Htrans(htrans[1]), .Haddr(haddr[1]),
        .Hwrite(hwrite[1]), .Hsize(hsize[1]), .Hprot(hprot[1]), .Hwdata(hwdata[1]),
        .Hreadyin(hreadyin[1]), .Hrdata(hrdata[1]), .Hreadyout(hreadyout[1]), .Hresp(hresp[1])
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic beat_t mk(input bit ready, input bit resp, input bit rd, input bit wr,
                                 input int unsigned addr, input int unsigned size);
        beat_t b;
        b.ready = ready; b.resp = resp; b.rd = rd; b.wr = wr; b.addr = addr; b.size = size;
        return b;
    endfunction

    function automatic logic [31:0] model_word(input int d, input int unsigned addr);
        int unsigned w;
        w = addr & 32'hFFFF_FFFC;
        return {mb[d][w+3], mb[d][w+2], mb[d][w+1], mb[d][w]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Little-endian byte lanes: a transfer of 2**size bytes at addr touches lanes addr%4 upward.
    task automatic commit(input int d, input int unsigned addr, input int unsigned size);
        int unsigned w;
        int unsigned lane;
        w = addr & 32'hFFFF_FFFC;
        for (int b = 0; b < (1 << size); b++) begin
            lane = (addr % 4) + b;
            mb[d][w + lane] = hwdata[d][lane*8 +: 8];
        end
    endtask

    task automatic model_edge(input int d);
        int unsigned a;
        int unsigned s;
        acc[d] = 1'b0;
        if (hreset) begin
            for (int i = 0; i < 1024; i++) mb[d][i] = 8'h00;
            pend_n[d] = 0;
            pend_pos[d] = 0;
            cur[d] = mk(1, 0, 0, 0, 0, 0);
            return;
        end
        if (cur[d].wr && cur[d].ready) commit(d, cur[d].addr, cur[d].size);
        if (cur[d].ready && hsel[d] && hreadyin[d] && htrans[d][1]) begin
            acc[d] = 1'b1;
            a = haddr[d];
            s = hsize[d];
            pend_pos[d] = 0;
            if (a >= 1024 || s > 2 || (a % (1 << s)) != 0) begin
                pend[d][0] = mk(0, 1, 0, 0, a, s);
                pend[d][1] = mk(1, 1, 0, 0, a, s);
                pend_n[d] = 2;
            end else begin
                for (int i = 0; i < ws_of(d); i++) pend[d][i] = mk(0, 0, 0, 0, a, s);
                pend[d][ws_of(d)] = mk(1, 0, !hwrite[d], hwrite[d], a, s);
                pend_n[d] = ws_of(d) + 1;
            end
        end
        if (pend_pos[d] < pend_n[d]) begin
            cur[d] = pend[d][pend_pos[d]];
            pend_pos[d]++;
        end else begin
            cur[d] = mk(1, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur[d] = mk(1, 0, 0, 0, 0, 0);
            pend_n[d] = 0;
            pend_pos[d] = 0;
            low_run[d] = 0;
            last_low[d] = 0;
            last_rdata[d] = 32'h0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_edge(d);
            started = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] exp_rd;
                exp_rd = (cur[d].rd && cur[d].ready) ? model_word(d, cur[d].addr) : 32'h0;
                check($sformatf("dut%0d hreadyout", d), {31'h0, hreadyout[d]}, {31'h0, cur[d].ready});
                check($sformatf("dut%0d hresp", d), {31'h0, hresp[d]}, {31'h0, cur[d].resp});
                check($sformatf("dut%0d hrdata", d), hrdata[d], exp_rd);
                if (cur[d].rd && cur[d].ready) last_rdata[d] = hrdata[d];
                if (hreadyout[d] === 1'b1) begin
                    if (low_run[d] != 0) last_low[d] = low_run[d];
                    low_run[d] = 0;
                end else begin
                    low_run[d]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit sel, input logic [1:0] trans, input bit rdyin,
                         input bit write, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output int ncyc);
        hsel[d] = sel; htrans[d] = trans; hreadyin[d] = rdyin; hwrite[d] = write;
        haddr[d] = addr; hsize[d] = size; hprot[d] = 4'($urandom);
        ncyc = 0;
        do begin
            tick();
            ncyc++;
        end while (!acc[d] && sel && rdyin && trans[1] && ncyc < 40);
        if (sel && rdyin && trans[1] && !acc[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept dut%0d addr %h: not taken after %0d cycles, required within 40",
                     d, addr, ncyc);
        end
        if (acc[d]) hwdata[d] = write ? wdata : $urandom;
    endtask

    task automatic wr(input int d, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        int nc;
        issue(d, 1'b1, 2'b10, 1'b1, 1'b1, addr, size, data, nc);
    endtask

    task automatic rd(input int d, input logic [31:0] addr, input logic [2:0] size, output int nc);
        issue(d, 1'b1, 2'b10, 1'b1, 1'b0, addr, size, 32'h0, nc);
    endtask

    task automatic idle(input int d, input int n);
        hsel[d] = 1'b0;
        htrans[d] = 2'b00;
        hreadyin[d] = 1'b1;
        repeat (n) tick();
    endtask

    task automatic rand_run(input int d, input int n);
        logic [1:0]  trans;
        logic [2:0]  size;
        logic [31:0] addr;
        int          r;
        int          nc;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            trans = (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b01;
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r = $urandom_range(0, 19);
            if (r < 14)
                addr = 32'($urandom_range(0, 31) * 4) + ((size == 3'd0) ? 32'($urandom_range(0, 3)) :
                                                         (size == 3'd1) ? 32'($urandom_range(0, 1) * 2) : 32'h0);
            else if (r < 16) addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            else if (r < 19) addr = 32'($urandom_range(1016, 1031));
            else             addr = $urandom | 32'h8000_0000;
            issue(d, $urandom_range(0, 11) != 0, trans, $urandom_range(0, 15) != 0,
                  1'($urandom_range(0, 1)), addr, size, $urandom, nc);
            if ($urandom_range(0, 7) == 0) idle(d, $urandom_range(1, 3));
        end
    endtask

    initial begin
        int nc;
        hreset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = 32'h0; hwrite[d] = 1'b0;
            hsize[d] = 3'd0; hprot[d] = 4'h0; hwdata[d] = 32'h0; hreadyin[d] = 1'b1;
        end
        repeat (3) tick();
        hreset = 1'b0;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dut%0d hreadyout", d), {31'h0, hreadyout[d]}, 32'h1);
            check($sformatf("reset dut%0d hresp", d), {31'h0, hresp[d]}, 32'h0);
            check($sformatf("reset dut%0d hrdata", d), hrdata[d], 32'h0);
        end

        // Back-to-back write then read, zero wait states.
        wr(0, 32'h10, 3'd2, 32'hDEAD_BEEF);
        rd(0, 32'h10, 3'd2, nc);
        check("read accepted without bubble", nc, 32'd1);
        idle(0, 2);
        check("write/read 0x10", last_rdata[0], 32'hDEAD_BEEF);

        // Byte and halfword merges into an existing word.
        wr(0, 32'h10, 3'd2, 32'h1122_3344);
        wr(0, 32'h13, 3'd0, {8'hAA, 24'($urandom)});
        rd(0, 32'h10, 3'd2, nc);
        idle(0, 2);
        check("byte lane 3 merge", last_rdata[0], 32'hAA22_3344);
        wr(0, 32'h10, 3'd1, {16'($urandom), 16'h5566});
        rd(0, 32'h10, 3'd2, nc);
        idle(0, 2);
        check("halfword lanes 1:0 merge", last_rdata[0], 32'hAA22_5566);
        check("model word 0x10", model_word(0, 32'h10), 32'hAA22_5566);

        // Error transfers back to back, including writes that must not land.
        rd(0, 32'h400, 3'd2, nc);
        rd(0, 32'h02, 3'd2, nc);
        check("error to error spacing", nc, 32'd2);
        rd(0, 32'h0, 3'd3, nc);
        wr(0, 32'h11, 3'd1, 32'hFFFF_FFFF);
        wr(0, 32'h10, 3'd3, 32'hFFFF_FFFF);
        wr(0, 32'h410, 3'd2, 32'hFFFF_FFFF);
        idle(0, 3);
        check("error low cycles", last_low[0], 32'd1);
        rd(0, 32'h10, 3'd2, nc);
        idle(0, 2);
        check("errors leave memory", last_rdata[0], 32'hAA22_5566);

        // BUSY, deselected and not-ready address phases must not access memory.
        hwdata[0] = 32'h0;
        issue(0, 1'b1, 2'b01, 1'b1, 1'b1, 32'h10, 3'd2, 32'h0, nc);
        issue(0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h10, 3'd2, 32'h0, nc);
        issue(0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h10, 3'd2, 32'h0, nc);
        idle(0, 2);
        rd(0, 32'h10, 3'd2, nc);
        idle(0, 2);
        check("ignored phases leave memory", last_rdata[0], 32'hAA22_5566);

        // Three wait states.
        wr(1, 32'h20, 3'd2, 32'hCAFE_F00D);
        rd(1, 32'h20, 3'd2, nc);
        check("read waits out write data phase", nc, 32'd4);
        idle(1, 6);
        check("wait-state low cycles", last_low[1], 32'd3);
        check("wait-state read 0x20", last_rdata[1], 32'hCAFE_F00D);

        // Reset in the second wait cycle of a write aborts it.
        wr(1, 32'h40, 3'd2, 32'h1234_5678);
        idle(1, 1);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check("ready after reset abort", {31'h0, hreadyout[1]}, 32'h1);
        rd(1, 32'h40, 3'd2, nc);
        check("accept right after reset", nc, 32'd1);
        idle(1, 6);
        check("aborted write not committed", last_rdata[1], 32'h0);
        rd(1, 32'h20, 3'd2, nc);
        idle(1, 6);
        check("reset cleared 0x20", last_rdata[1], 32'h0);

        rand_run(0, 250);
        idle(0, 3);
        rand_run(1, 150);
        idle(1, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
